// File: rtl/red_centroid_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | red_centroid_if : pixel stream in, centroid result out             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface red_centroid_if;
  logic        red_pixel;
  logic        pixel_valid;
  logic [9:0]  x_cont;
  logic [8:0]  y_cont;
  logic        v_sync;
  logic [9:0]  vert_line;
  logic [8:0]  horz_line;
  logic        ball_found;
  logic        centroid_valid;
  logic [18:0] pixel_count;
  logic        frame_dropped;

  modport master (
    output red_pixel, pixel_valid, x_cont, y_cont, v_sync,
    input  vert_line, horz_line, ball_found, centroid_valid, pixel_count, frame_dropped
  );

  modport slave (
    input  red_pixel, pixel_valid, x_cont, y_cont, v_sync,
    output vert_line, horz_line, ball_found, centroid_valid, pixel_count, frame_dropped
  );
endinterface
`default_nettype wire

// File: rtl/red_centroid.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | red_centroid : per-frame centroid of red pixels via serial divide  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module red_centroid #(
  parameter int MIN_PIXELS = 16,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic          ball_clock,
  input  logic          reset,
  red_centroid_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, UPDATE = 2'd2} state_t;

  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM   = 10'(V_ACTIVE);
  localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

  state_t      state_q, state_d;
  logic        vs_q;
  logic [18:0] cnt_q;
  logic [27:0] sumx_q, sumy_q;
  logic [18:0] den_q, remx_q, remy_q;
  logic [27:0] quox_q, quoy_q;
  logic [4:0]  step_q;
  logic [9:0]  vert_q;
  logic [8:0]  horz_q;
  logic        found_q, valid_q, dropped_q;
  logic [18:0] pcount_q;

  logic        frame_end;
  logic        pix_hit;
  logic [46:0] stepx, stepy;

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [46:0] div_step(input logic [18:0] rem, input logic [27:0] quo,
                                           input logic [18:0] den);
    logic [19:0] trial;
    trial = {rem, quo[27]};
    if (trial >= {1'b0, den}) return {19'(trial - {1'b0, den}), quo[26:0], 1'b1};
    else                      return {trial[18:0], quo[26:0], 1'b0};
  endfunction

  assign frame_end = vs_q & ~bus.v_sync;
  assign pix_hit   = bus.red_pixel & bus.pixel_valid & bus.v_sync &
                     ({1'b0, bus.x_cont} < H_LIM) & ({1'b0, bus.y_cont} < V_LIM);
  assign stepx     = div_step(remx_q, quox_q, den_q);
  assign stepy     = div_step(remy_q, quoy_q, den_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_end) state_d = (cnt_q >= MIN_CNT) ? DIVIDE : UPDATE;
      DIVIDE:  if (step_q == 5'd27) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ball_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      vs_q      <= 1'b0;
      cnt_q     <= '0;
      sumx_q    <= '0;
      sumy_q    <= '0;
      den_q     <= '0;
      remx_q    <= '0;
      remy_q    <= '0;
      quox_q    <= '0;
      quoy_q    <= '0;
      step_q    <= '0;
      vert_q    <= 10'h3FF;
      horz_q    <= 9'h1FF;
      found_q   <= 1'b0;
      pcount_q  <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= bus.v_sync;
      valid_q   <= 1'b0;
      dropped_q <= frame_end && (state_q != IDLE);

      // Accumulators restart at every frame end, even when the frame is dropped.
      if (frame_end) begin
        cnt_q  <= '0;
        sumx_q <= '0;
        sumy_q <= '0;
      end else if (pix_hit) begin
        cnt_q  <= cnt_q + 19'd1;
        sumx_q <= sumx_q + {18'd0, bus.x_cont};
        sumy_q <= sumy_q + {19'd0, bus.y_cont};
      end

      case (state_q)
        IDLE: begin
          if (frame_end) begin
            den_q  <= cnt_q;
            quox_q <= sumx_q;
            quoy_q <= sumy_q;
            remx_q <= '0;
            remy_q <= '0;
            step_q <= '0;
            if (cnt_q < MIN_CNT) begin
              vert_q   <= 10'h3FF;
              horz_q   <= 9'h1FF;
              found_q  <= 1'b0;
              pcount_q <= cnt_q;
              valid_q  <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          {remx_q, quox_q} <= stepx;
          {remy_q, quoy_q} <= stepy;
          step_q           <= step_q + 5'd1;
          // The last quotient bit is taken straight from the step so results land with the UPDATE cycle.
          if (state_d == UPDATE) begin
            vert_q   <= stepx[9:0];
            horz_q   <= stepy[8:0];
            found_q  <= 1'b1;
            pcount_q <= den_q;
            valid_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vert_line      = vert_q;
  assign bus.horz_line      = horz_q;
  assign bus.ball_found     = found_q;
  assign bus.pixel_count    = pcount_q;
  assign bus.centroid_valid = valid_q;
  assign bus.frame_dropped  = dropped_q;
endmodule
`default_nettype wire

// File: tb/tb_red_centroid.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_red_centroid : two thresholds (1 and 16) driven with one stream |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_red_centroid;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  logic       clk = 1'b0;
  logic       rst;
  logic       red, pv, vs;
  logic [9:0] x;
  logic [8:0] y;

  always #5 clk = ~clk;

  red_centroid_if if1 ();
  red_centroid_if if16 ();

  assign if1.red_pixel    = red;
  assign if1.pixel_valid  = pv;
  assign if1.x_cont       = x;
  assign if1.y_cont       = y;
  assign if1.v_sync       = vs;
  assign if16.red_pixel   = red;
  assign if16.pixel_valid = pv;
  assign if16.x_cont      = x;
  assign if16.y_cont      = y;
  assign if16.v_sync      = vs;

  red_centroid #(.MIN_PIXELS(1), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_dut1 (
    .ball_clock(clk), .reset(rst), .bus(if1));
  red_centroid #(.MIN_PIXELS(16), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_dut16 (
    .ball_clock(clk), .reset(rst), .bus(if16));

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int e_cyc = 0;

  // Frame-level model: cycle numbers at which each result or drop must appear.
  int     min_px[2] = '{1, 16};
  bit     m_prev_vs = 1'b0;
  longint m_cnt = 0, m_sx = 0, m_sy = 0;
  int     busy_last[2] = '{-1, -1};
  int     pend_cyc[2]  = '{-1, -1};
  int     drop_cyc[2]  = '{-1, -1};
  int     pend_v[2], pend_h[2], pend_c[2];
  bit     pend_f[2];
  int     exp_v[2] = '{1023, 1023};
  int     exp_h[2] = '{511, 511};
  int     exp_c[2] = '{0, 0};
  bit     exp_f[2] = '{0, 0};
  int     n_valid[2] = '{0, 0};
  int     n_drop[2]  = '{0, 0};
  int     last_valid_cyc[2] = '{-1, -1};

  always @(posedge clk) begin
    int cur;
    cur = cyc;
    if (rst) begin
      m_prev_vs = 1'b0;
      m_cnt = 0; m_sx = 0; m_sy = 0;
      for (int i = 0; i < 2; i++) begin
        busy_last[i] = -1; pend_cyc[i] = -1; drop_cyc[i] = -1;
        exp_v[i] = 1023; exp_h[i] = 511; exp_c[i] = 0; exp_f[i] = 1'b0;
      end
    end else begin
      if (m_prev_vs && !vs) begin
        for (int i = 0; i < 2; i++) begin
          if (cur <= busy_last[i]) begin
            drop_cyc[i] = cur + 1;
          end else if (m_cnt >= longint'(min_px[i])) begin
            pend_cyc[i] = cur + 29; busy_last[i] = cur + 29;
            pend_v[i] = int'(m_sx / m_cnt); pend_h[i] = int'(m_sy / m_cnt);
            pend_c[i] = int'(m_cnt); pend_f[i] = 1'b1;
          end else begin
            pend_cyc[i] = cur + 1; busy_last[i] = cur + 1;
            pend_v[i] = 1023; pend_h[i] = 511; pend_c[i] = int'(m_cnt); pend_f[i] = 1'b0;
          end
        end
        m_cnt = 0; m_sx = 0; m_sy = 0;
      end else if (red && pv && vs && int'(x) < H_ACTIVE && int'(y) < V_ACTIVE) begin
        m_cnt = m_cnt + 1; m_sx = m_sx + longint'(x); m_sy = m_sy + longint'(y);
      end
      m_prev_vs = vs;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [40:0] act, expv;
        bit ev, ed;
        ev = (cyc == pend_cyc[i]);
        ed = (cyc == drop_cyc[i]);
        if (ev) begin
          exp_v[i] = pend_v[i]; exp_h[i] = pend_h[i]; exp_c[i] = pend_c[i]; exp_f[i] = pend_f[i];
        end
        if (i == 0)
          act = {if1.vert_line, if1.horz_line, if1.ball_found, if1.pixel_count,
                 if1.centroid_valid, if1.frame_dropped};
        else
          act = {if16.vert_line, if16.horz_line, if16.ball_found, if16.pixel_count,
                 if16.centroid_valid, if16.frame_dropped};
        expv = {10'(exp_v[i]), 9'(exp_h[i]), exp_f[i], 19'(exp_c[i]), ev, ed};
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL model[%0d] cyc %0d: got v=%h h=%h f=%b c=%0d val=%b drp=%b expected v=%h h=%h f=%b c=%0d val=%b drp=%b",
                      i, cyc, act[40:31], act[30:22], act[21], act[20:2], act[1], act[0],
                      expv[40:31], expv[30:22], expv[21], expv[20:2], expv[1], expv[0]);
        if (act[1] === 1'b1) begin n_valid[i]++; last_valid_cyc[i] = cyc; end
        if (act[0] === 1'b1) n_drop[i]++;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  task automatic drive(input bit r, input bit v, input int xx, input int yy);
    @(negedge clk);
    red = r; pv = v; x = 10'(xx); y = 9'(yy);
  endtask

  task automatic vs_on();
    @(negedge clk);
    vs = 1'b1; red = 1'b0; pv = 1'b0;
  endtask

  task automatic vs_off(input bit r, input int xx, input int yy);
    @(negedge clk);
    vs = 1'b0; red = r; pv = r; x = 10'(xx); y = 9'(yy);
    e_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      red = 1'b0; pv = 1'b0;
    end
  endtask

  initial begin
    int e1, nv;
    rst = 1'b1; red = 1'b0; pv = 1'b0; vs = 1'b0; x = '0; y = '0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset vert", if16.vert_line, 1023);
    chk("reset horz", if16.horz_line, 511);
    chk("reset found", if16.ball_found, 0);
    chk("reset count", if16.pixel_count, 0);

    // Single pixel at (100,50).
    vs_on();
    drive(1, 1, 100, 50);
    vs_off(0, 0, 0);
    idle(35);
    chk("single vert", if1.vert_line, 100);
    chk("single horz", if1.horz_line, 50);
    chk("single count", if1.pixel_count, 1);
    chk("single found", if1.ball_found, 1);
    chk("single latency", last_valid_cyc[0] - e_cyc, 29);
    chk("single pulses", n_valid[0], 1);
    chk("below latency", last_valid_cyc[1] - e_cyc, 1);

    // 10x10 block, centroid 204.5/104.5 floors to 204/104.
    vs_on();
    for (int yy = 100; yy < 110; yy++)
      for (int xx = 200; xx < 210; xx++) drive(1, 1, xx, yy);
    vs_off(0, 0, 0);
    idle(35);
    chk("block vert", if16.vert_line, 204);
    chk("block horz", if16.horz_line, 104);
    chk("block count", if16.pixel_count, 100);
    chk("block found", if16.ball_found, 1);

    // 15 pixels is one short of the threshold.
    vs_on();
    for (int k = 0; k < 15; k++) drive(1, 1, 10 + k, 20);
    vs_off(0, 0, 0);
    idle(3);
    chk("short count", if16.pixel_count, 15);
    chk("short found", if16.ball_found, 0);
    chk("short vert", if16.vert_line, 1023);
    chk("short latency", last_valid_cyc[1] - e_cyc, 1);
    idle(32);
    chk("short min1 vert", if1.vert_line, 17);

    // Only ignored pixels, plus a red pixel presented in the frame-end cycle.
    vs_on();
    drive(1, 0, 50, 50);
    drive(1, 1, 700, 50);
    drive(1, 1, 50, 480);
    vs_off(1, 30, 30);
    idle(35);
    chk("ignored count", if1.pixel_count, 0);
    chk("ignored found", if1.ball_found, 0);

    // Second frame end 10 cycles after the first while dividing.
    vs_on();
    for (int k = 0; k < 4; k++) drive(1, 1, 300 + k, 200);
    vs_off(0, 0, 0);
    e1 = e_cyc;
    vs_on();
    drive(1, 1, 400, 300);
    idle(7);
    vs_off(0, 0, 0);
    idle(40);
    chk("drop pulses min1", n_drop[0], 1);
    chk("drop pulses min16", n_drop[1], 0);
    chk("drop vert", if1.vert_line, 301);
    chk("drop horz", if1.horz_line, 200);
    chk("drop count", if1.pixel_count, 4);
    chk("drop latency", last_valid_cyc[0] - e1, 29);

    // Reset in the middle of a divide.
    vs_on();
    for (int k = 0; k < 4; k++) drive(1, 1, 300 + k, 200);
    vs_off(0, 0, 0);
    nv = n_valid[0];
    idle(12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(30);
    chk("abort pulses", n_valid[0], nv);
    chk("abort vert", if1.vert_line, 1023);
    chk("abort horz", if1.horz_line, 511);
    chk("abort found", if1.ball_found, 0);
    vs_on();
    drive(1, 1, 5, 6);
    drive(1, 1, 7, 8);
    vs_off(0, 0, 0);
    idle(35);
    chk("after vert", if1.vert_line, 6);
    chk("after horz", if1.horz_line, 7);
    chk("after count", if1.pixel_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/red_centroid.md
RED_CENTROID -- requirements
Module: red_centroid

Interface
REQ-001 SHALL have parameter MIN_PIXELS, default 16: minimum red-pixel count for a frame to report a ball.
REQ-002 SHALL have parameter H_ACTIVE, default 640: active columns; pixels with x_cont >= H_ACTIVE are ignored.
REQ-003 SHALL have parameter V_ACTIVE, default 480: active rows; pixels with y_cont >= V_ACTIVE are ignored.
REQ-004 SHALL have port ball_clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port red_pixel, input, 1 bit: filtered red-detection flag for the current pixel.
REQ-007 SHALL have port pixel_valid, input, 1 bit: high when the current pixel lies in the active area.
REQ-008 SHALL have port x_cont, input, 10 bits: column of the current pixel.
REQ-009 SHALL have port y_cont, input, 9 bits: row of the current pixel.
REQ-010 SHALL have port v_sync, input, 1 bit: high during the vertical active region; its falling edge marks frame end.
REQ-011 SHALL have port vert_line, output, 10 bits: centroid column; 10'h3FF when no ball.
REQ-012 SHALL have port horz_line, output, 9 bits: centroid row; 9'h1FF when no ball.
REQ-013 SHALL have port ball_found, output, 1 bit: last completed frame met MIN_PIXELS.
REQ-014 SHALL have port centroid_valid, output, 1 bit: one-cycle pulse when the outputs update.
REQ-015 SHALL have port pixel_count, output, 19 bits: red-pixel count of the last completed frame.
REQ-016 SHALL have port frame_dropped, output, 1 bit: one-cycle pulse when a frame end is discarded.

Function
REQ-017 SHALL count a pixel iff red_pixel & pixel_valid & v_sync & (x_cont < H_ACTIVE) & (y_cont < V_ACTIVE); on a counted pixel: cnt += 1, sum_x += x_cont, sum_y += y_cont.
REQ-018 SHALL size cnt at 19 bits and sum_x/sum_y at 28 bits each; no saturation is needed at 640x480.
REQ-019 SHALL register v_sync once (vs_q); frame-end event E is the cycle where vs_q=1 and v_sync=0.
REQ-020 SHALL, in cycle E, copy cnt/sum_x/sum_y into divider operands and clear the accumulators in the same cycle; the next frame accumulates in parallel with division.
REQ-021 SHALL implement FSM states IDLE, DIVIDE, UPDATE.
REQ-022 FSM transition: IDLE -> DIVIDE at E when cnt >= MIN_PIXELS.
REQ-023 FSM transition: IDLE -> UPDATE at E when cnt < MIN_PIXELS; no divide is performed.
REQ-024 FSM transition: DIVIDE -> UPDATE after exactly 28 cycles.
REQ-025 FSM transition: UPDATE -> IDLE after 1 cycle.
REQ-026 DIVIDE SHALL run two 28-bit by 19-bit restoring dividers in parallel, one quotient bit per cycle; quotients are truncated (floor).
REQ-027 SHALL, in UPDATE with count >= MIN_PIXELS, load vert_line=quot_x[9:0], horz_line=quot_y[8:0], ball_found=1, pixel_count=snapshot count, and pulse centroid_valid.
REQ-028 SHALL, in UPDATE with count < MIN_PIXELS, load vert_line=10'h3FF, horz_line=9'h1FF, ball_found=0, pixel_count=snapshot count, and pulse centroid_valid.
REQ-029 Latency: centroid_valid SHALL assert at E+29 on the divide path and at E+1 on the below-threshold path.
REQ-030 SHALL hold vert_line, horz_line, ball_found and pixel_count stable between updates.
REQ-031 SHALL, when E occurs while the FSM is not in IDLE, still clear the accumulators, leave the divider undisturbed, pulse frame_dropped, and make no output update for that frame.
REQ-032 SHALL not count a pixel presented in cycle E (v_sync=0).

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set FSM=IDLE, zero the accumulators, set vs_q=0, vert_line=10'h3FF, horz_line=9'h1FF, ball_found=0, pixel_count=0, centroid_valid=0, frame_dropped=0.
REQ-034 Reset SHALL abort a divide in progress with no centroid_valid pulse; the first E after reset starts a fresh frame.

Verification
REQ-035 MIN_PIXELS=1, single red pixel at (100,50), frame end -> at E+29: vert_line=100, horz_line=50, pixel_count=1, ball_found=1, one centroid_valid pulse.
REQ-036 10x10 block x 200..209, y 100..109 -> pixel_count=100, vert_line=204, horz_line=104 (204.5 floor), at E+29.
REQ-037 Frame with 15 red pixels, MIN_PIXELS=16 -> at E+1: vert_line=3FF, horz_line=1FF, ball_found=0, pixel_count=15.
REQ-038 Red pixels with pixel_valid=0 or x_cont=700 -> not counted; an otherwise empty frame gives pixel_count=0.
REQ-039 Second v_sync falling edge 10 cycles after the first -> frame_dropped pulse; first frame's result still arrives at its E+29.
REQ-040 reset asserted at E+12 -> no centroid_valid pulse; outputs read 3FF/1FF/0; the next frame computes correctly.
